// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared ISA constants and types for the instruction-fetch stage.
//   OP_HLT        : opcode (instr[15:12]) that stops fetch
//   RESET_PC      : PC value after reset
//   BUBBLE_INSTR  : instruction word loaded into IF/ID for a bubble
//   fetch_state_t : fetch FSM state (RUN / HALT)
//   if_id_t       : packed 33-bit IF/ID pipeline register contents
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [3:0]  OP_HLT       = 4'hF;
    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;
    localparam logic [15:0] PC_STEP      = 16'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// 33-bit IF/ID pipeline register with hold and synchronous clear-to-bubble.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears every field
//   en  : load d (when low and clr low, the register holds)
//   clr : load a bubble (instr=BUBBLE_INSTR, valid=0); pc_plus2 is kept
//   d   : next contents
//   q   : registered contents
// Priority: rst > clr > en.
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg.instr    <= BUBBLE_INSTR;
            q_reg.pc_plus2 <= RESET_PC;
            q_reg.valid    <= 1'b0;
        end else if (clr) begin
            // A bubble keeps the old pc_plus2: nothing downstream reads it
            // while valid is low, and holding it avoids extra muxing.
            q_reg.instr <= BUBBLE_INSTR;
            q_reg.valid <= 1'b0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: PC register, RUN/HALT FSM and the IF/ID register.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset, overrides everything
//   stall          : hazard hold from decode (ignored while halted)
//   branch_taken   : redirect from decode; wins over stall
//   branch_target  : redirect byte address (bit 0 forced to 0)
//   imem_addr      : instruction memory address, always equal to PC
//   imem_data      : instruction word at imem_addr, same cycle
//   if_id_instr    : latched instruction word
//   if_id_pc_plus2 : PC+2 of the latched instruction
//   if_id_valid    : IF/ID holds a real instruction
//   halted         : sticky, set when HLT is fetched, cleared by branch/reset
//   fetch_count    : instructions latched into IF/ID, wraps at 2^16
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    fetch_state_t state_reg;
    logic [15:0]  pc_reg;
    logic         halted_reg;
    logic [15:0]  fetch_count_reg;

    logic [15:0]  pc_plus2;
    logic [15:0]  branch_pc;
    logic         fetch_is_hlt;
    logic         fetch_en;
    logic         ifid_en;
    logic         ifid_clr;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_plus2     = pc_reg + PC_STEP;
    assign branch_pc    = branch_target & 16'hFFFE;
    assign fetch_is_hlt = (imem_data[15:12] == OP_HLT);

    // A real instruction is latched only in RUN with no redirect or stall.
    assign fetch_en = (state_reg == ST_RUN) && !branch_taken && !stall;

    // Redirects always inject a bubble; HALT injects one every cycle,
    // regardless of stall.
    assign ifid_clr = branch_taken || (state_reg == ST_HALT);
    assign ifid_en  = fetch_en;

    always_comb begin
        ifid_d          = '0;
        ifid_d.instr    = imem_data;
        ifid_d.pc_plus2 = pc_plus2;
        ifid_d.valid    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            pc_reg          <= RESET_PC;
            halted_reg      <= 1'b0;
            fetch_count_reg <= 16'h0000;
        end else if (branch_taken) begin
            state_reg  <= ST_RUN;
            pc_reg     <= branch_pc;
            halted_reg <= 1'b0;
        end else if (fetch_en) begin
            fetch_count_reg <= fetch_count_reg + 16'd1;
            if (fetch_is_hlt) begin
                // PC stays parked on the HLT word.
                state_reg  <= ST_HALT;
                halted_reg <= 1'b1;
            end else begin
                pc_reg <= pc_plus2;
            end
        end
        // Otherwise: stall in RUN or idle in HALT -- everything holds.
    end

    if_id_reg u_if_id_reg (
        .clk (clk),
        .rst (rst),
        .en  (ifid_en),
        .clr (ifid_clr),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign imem_addr      = pc_reg;
    assign if_id_instr    = ifid_q.instr;
    assign if_id_pc_plus2 = ifid_q.pc_plus2;
    assign if_id_valid    = ifid_q.valid;
    assign halted         = halted_reg;
    assign fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed stimulus for fetch_stage. The driver applies one vector per cycle
// on the falling edge and pushes the hand-computed post-edge state into a
// queue; a monitor pops one entry after each rising edge and compares.
// Instruction memory: 0x000A holds HLT (0xF000), every other address holds
// an ADD-class word {4'h1, addr[11:0]}.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    typedef struct {
        int          idx;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        halted;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_idx  = 0;
    bit   drive_done = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Combinational-read instruction memory model.
    always_comb begin
        if (imem_addr == 16'h000A) imem_data = 16'hF000;
        else                       imem_data = {4'h1, imem_addr[11:0]};
    end

    task automatic check16(input int idx, input string name,
                           input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL vec%0d %s: got 0x%04h expected 0x%04h", idx, name, act, req);
        end
    endtask

    // One vector: inputs for this cycle and the expected state after the edge.
    task automatic step(input logic r, input logic s, input logic b,
                        input logic [15:0] tgt,
                        input logic [15:0] e_pc, input logic [15:0] e_instr,
                        input logic [15:0] e_pc2, input logic e_v,
                        input logic e_h, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        e.idx    = vec_idx;
        e.pc     = e_pc;
        e.instr  = e_instr;
        e.pc2    = e_pc2;
        e.valid  = e_v;
        e.halted = e_h;
        e.count  = e_cnt;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check16(e.idx, "imem_addr",      imem_addr,      e.pc);
                check16(e.idx, "if_id_instr",    if_id_instr,    e.instr);
                check16(e.idx, "if_id_pc_plus2", if_id_pc_plus2, e.pc2);
                check16(e.idx, "if_id_valid",    {15'd0, if_id_valid}, {15'd0, e.valid});
                check16(e.idx, "halted",         {15'd0, halted},      {15'd0, e.halted});
                check16(e.idx, "fetch_count",    fetch_count,    e.count);
                $display("vec%0d: pc=%04h instr=%04h pc2=%04h v=%0b h=%0b cnt=%0d",
                         e.idx, imem_addr, if_id_instr, if_id_pc_plus2,
                         if_id_valid, halted, fetch_count);
            end
        end
    end

    // Driver
    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        //    rst  stl  bt   tgt       pc       instr    pc2      v  h  cnt
        // Reset, then three sequential ADD fetches.
        step(1'b1,1'b0,1'b0,16'h0000, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1000,16'h0002,1'b1,1'b0,16'd1);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0004,16'h1002,16'h0004,1'b1,1'b0,16'd2);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0006,16'h1004,16'h0006,1'b1,1'b0,16'd3);
        // Reset again, fetch to PC=4, stall two cycles, resume.
        step(1'b1,1'b0,1'b0,16'h0000, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1000,16'h0002,1'b1,1'b0,16'd1);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0004,16'h1002,16'h0004,1'b1,1'b0,16'd2);
        step(1'b0,1'b1,1'b0,16'h0000, 16'h0004,16'h1002,16'h0004,1'b1,1'b0,16'd2);
        step(1'b0,1'b1,1'b0,16'h0000, 16'h0004,16'h1002,16'h0004,1'b1,1'b0,16'd2);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0006,16'h1004,16'h0006,1'b1,1'b0,16'd3);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0008,16'h1006,16'h0008,1'b1,1'b0,16'd4);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h000A,16'h1008,16'h000A,1'b1,1'b0,16'd5);
        // HLT at 0x000A: latched, PC parked, then bubbles (stall ignored).
        step(1'b0,1'b0,1'b0,16'h0000, 16'h000A,16'hF000,16'h000C,1'b1,1'b1,16'd6);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h000A,16'h0000,16'h000C,1'b0,1'b1,16'd6);
        step(1'b0,1'b1,1'b0,16'h0000, 16'h000A,16'h0000,16'h000C,1'b0,1'b1,16'd6);
        // Branch + stall out of HALT to odd target 0x0031 -> 0x0030.
        step(1'b0,1'b1,1'b1,16'h0031, 16'h0030,16'h0000,16'h000C,1'b0,1'b0,16'd6);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0032,16'h1030,16'h0032,1'b1,1'b0,16'd7);
        // Branch in RUN to 0xFFFE, then PC wraps to 0x0000.
        step(1'b0,1'b0,1'b1,16'hFFFE, 16'hFFFE,16'h0000,16'h0032,1'b0,1'b0,16'd7);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0000,16'h1FFE,16'h0000,1'b1,1'b0,16'd8);
        // Branch to HLT, halt, then reset together with branch_taken.
        step(1'b0,1'b0,1'b1,16'h000A, 16'h000A,16'h0000,16'h0000,1'b0,1'b0,16'd8);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h000A,16'hF000,16'h000C,1'b1,1'b1,16'd9);
        step(1'b1,1'b1,1'b1,16'h1234, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,16'd0);
        step(1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1000,16'h0002,1'b1,1'b0,16'd1);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        drive_done = 1'b1;
    end

    // Completion: wait for the scoreboard to drain, bounded by a cycle budget.
    initial begin
        int cycles = 0;
        while (!(drive_done && exp_q.size() == 0) && cycles < 1000) begin
            @(posedge clk);
            cycles++;
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || !drive_done) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
